// File: rtl/pll_seq_pkg.sv
// Shared types, register map and counter presets for the PLL reconfiguration sequencer.
package pll_seq_pkg;

    localparam int PRESET_CNT   = 4;
    localparam int PRESET_WORDS = 4;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_LOCKWAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_MODE     = 3'd3,
        ST_WR       = 3'd4,
        ST_START    = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } preset_word_t;

    // Words per preset: N, M, C0, C1. Bit 18 of a C word selects counter C1.
    localparam preset_word_t PRESET_TABLE [PRESET_CNT][PRESET_WORDS] = '{
        '{'{ADDR_N, 32'h0000_0202}, '{ADDR_M, 32'h0000_1010}, '{ADDR_C, 32'h0000_0404}, '{ADDR_C, 32'h0004_0808}},
        '{'{ADDR_N, 32'h0000_0101}, '{ADDR_M, 32'h0000_0C0C}, '{ADDR_C, 32'h0000_0505}, '{ADDR_C, 32'h0004_0A0A}},
        '{'{ADDR_N, 32'h0000_0303}, '{ADDR_M, 32'h0000_1B1B}, '{ADDR_C, 32'h0000_0606}, '{ADDR_C, 32'h0004_0C0C}},
        '{'{ADDR_N, 32'h0000_0202}, '{ADDR_M, 32'h0000_2424}, '{ADDR_C, 32'h0000_0303}, '{ADDR_C, 32'h0004_0707}}
    };

endpackage

// File: rtl/pll_reconfig_seq_lock_qual.sv
// Lock qualifier: synchronizes the raw PLL lock and requires LOCK_STABLE consecutive high cycles.
module pll_lock_qual #(
    parameter int LOCK_STABLE = 8
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_q
);

    localparam int CW = $clog2(LOCK_STABLE + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;

    // two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // stability counter; any synced low restarts qualification
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (!sync2_r) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (cnt_r < CW'(LOCK_STABLE - 1)) begin
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            stable_r <= 1'b1;
        end
    end

    // Gated with the synced level so lock loss is seen on the first low cycle.
    assign lock_q = stable_r & sync2_r;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reset / dynamic-reconfiguration sequencer on the 50 MHz reference clock.
// Optional PLL_SEQ_RELOCK_EN: lock loss while idle restarts the reset/lock sequence.
module pll_reconfig_seq
    import pll_seq_pkg::*;
#(
    parameter int NPRESET      = 4,
    parameter int NWORDS       = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 50000,
    localparam int SW = (NPRESET > 1) ? $clog2(NPRESET) : 1
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          cfg_req,
    input  logic [SW-1:0] cfg_sel,
    input  logic          pll_locked,
    output logic          pll_rst,
    output logic [5:0]    mgmt_address,
    output logic          mgmt_write,
    output logic [31:0]   mgmt_writedata,
    input  logic          mgmt_waitrequest,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CMAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int WW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    seq_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic [WW-1:0] widx_r;
    logic [SW-1:0] sel_r;
    logic          pend_valid_r;
    logic [SW-1:0] pend_sel_r;

    logic          lock_q_s;
    logic          relock_s;
    logic          take_s;
    logic [SW-1:0] req_sel_s;
    preset_word_t  cur_word_s;

    function automatic logic sel_valid(input logic [SW-1:0] sel);
        return (int'(sel) < NPRESET);
    endfunction

    pll_lock_qual #(.LOCK_STABLE(LOCK_STABLE)) u_lock_qual (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_q     (lock_q_s)
    );

`ifdef PLL_SEQ_RELOCK_EN
    assign relock_s = (state_r == ST_IDLE) && !lock_q_s;
`else
    assign relock_s = 1'b0;
`endif

    // request arbitration: a fresh strobe overrides the pending slot
    always_comb begin
        req_sel_s = pend_sel_r;
        take_s    = 1'b0;
        if (cfg_req) begin
            req_sel_s = cfg_sel;
        end else begin
            req_sel_s = pend_sel_r;
        end
        if ((state_r == ST_IDLE) && !relock_s && (cfg_req || pend_valid_r)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // address/data of the write owned by the current state
    always_comb begin
        cur_word_s = '{addr: 6'd0, data: 32'd0};
        case (state_r)
            ST_MODE:  cur_word_s = '{addr: ADDR_MODE, data: 32'd1};
            ST_WR:    cur_word_s = PRESET_TABLE[sel_r][widx_r];
            ST_START: cur_word_s = '{addr: ADDR_START, data: 32'd0};
            default:  cur_word_s = '{addr: 6'd0, data: 32'd0};
        endcase
    end

    // one-deep pending request slot, last request wins
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_sel_r   <= '0;
        end else if (cfg_req && !take_s) begin
            pend_valid_r <= 1'b1;
            pend_sel_r   <= cfg_sel;
        end else if (take_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // sequencer FSM with registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RST;
            cnt_r          <= '0;
            widx_r         <= '0;
            sel_r          <= '0;
            pll_rst        <= 1'b1;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_RST: begin
                    if (cnt_r == CW'(RST_CYCLES - 1)) begin
                        state_r <= ST_LOCKWAIT;
                        pll_rst <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                ST_LOCKWAIT: begin
                    if (lock_q_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
                        state_r <= ST_RST;
                        pll_rst <= 1'b1;
                        err     <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (relock_s) begin
                        state_r <= ST_RST;
                        pll_rst <= 1'b1;
                        busy    <= 1'b1;
                        cnt_r   <= '0;
                    end else if (take_s && sel_valid(req_sel_s)) begin
                        state_r        <= ST_MODE;
                        busy           <= 1'b1;
                        sel_r          <= req_sel_s;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= 32'd1;
                    end else if (take_s) begin
                        err <= 1'b1;
                    end
                end
                ST_MODE, ST_WR, ST_START: begin
                    if (!mgmt_write) begin
                        // Gap cycle over: present the next word.
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= cur_word_s.addr;
                        mgmt_writedata <= cur_word_s.data;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        if (state_r == ST_MODE) begin
                            state_r <= ST_WR;
                            widx_r  <= '0;
                        end else if (state_r == ST_START) begin
                            state_r <= ST_LOCKWAIT;
                            cnt_r   <= '0;
                        end else if (widx_r == WW'(NWORDS - 1)) begin
                            state_r <= ST_START;
                        end else begin
                            widx_r  <= widx_r + WW'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_RST;
                    pll_rst    <= 1'b1;
                    busy       <= 1'b1;
                    mgmt_write <= 1'b0;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Sequencer that owns the system PLL's reset and its dynamic-reconfiguration port. At power-up it pulses the PLL reset and waits for a qualified lock. On request it loads one of a fixed set of counter presets (for example, alternate video pixel clocks) through the Avalon-MM management interface of the PLL reconfiguration block, then waits for relock. It sits between the core's mode-select logic and the PLL/reconfig pair, on the 50 MHz reference clock.

## Interface
Parameters:
- `NPRESET`, 4: number of presets in the package table; `cfg_sel` width = `$clog2(NPRESET)`.
- `NWORDS`, 4: counter-register writes per preset (N, M, C0, C1).
- `RST_CYCLES`, 16: `pll_rst` high time.
- `LOCK_STABLE`, 8: cycles synced lock must stay high to qualify.
- `LOCK_TIMEOUT`, 50000: max cycles waiting for lock (1 ms at 50 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `refclk` in 1: 50 MHz clock, all logic.
- `rst_n` in 1: async active-low reset.
- `cfg_req` in 1: one-cycle request strobe.
- `cfg_sel` in log2(NPRESET): preset index, sampled with `cfg_req`.
- `pll_locked` in 1: raw PLL lock, asynchronous.
- `pll_rst` out 1: PLL reset, active high.
- `mgmt_address` out 6: reconfig register address.
- `mgmt_write` out 1: write strobe.
- `mgmt_writedata` out 32: write data.
- `mgmt_waitrequest` in 1: slave stall.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on a successful lock after reset or reconfig.
- `err` out 1: one-cycle pulse on lock timeout or bad `cfg_sel`.

## Operation
- Lock qualifier: 2-flop sync of `pll_locked`, then counter; `lock_q` asserts after `LOCK_STABLE` consecutive high cycles and drops on the first synced low.
- States:
  - RST: `pll_rst`=1 for `RST_CYCLES`, then LOCKWAIT.
  - LOCKWAIT: `lock_q` → IDLE with `done`. Timeout counter reaching `LOCK_TIMEOUT` → `err`, then RST (retry, unbounded).
  - IDLE: waits for a request.
  - MODE: write addr 0, data 1 (polling mode).
  - WR: write preset word k (addr/data from table), k = 0..NWORDS-1.
  - START: write addr 2, data 0.
  - After START, go to LOCKWAIT; the timeout counter is cleared on entry.
- Request handling:
  - `cfg_req` in IDLE with `cfg_sel` < NPRESET → MODE.
  - `cfg_sel` ≥ NPRESET → `err` pulse, stay IDLE.
  - `cfg_req` while busy → latched in a one-deep pending slot; the last request wins. The pending request is taken on the first cycle in IDLE, with no `done`-to-MODE gap beyond that cycle.
- Write handshake:
  - `mgmt_write`, address and data are registered and held constant while `mgmt_waitrequest`=1.
  - A write completes on the cycle with `mgmt_write`=1 and `mgmt_waitrequest`=0.
  - `mgmt_write` drops for exactly one cycle between consecutive writes.
- Reset mid-operation:
  - `rst_n` low aborts any state immediately.
  - Pending request and counters are cleared.
  - After release, the FSM enters RST.

## Timing
- Reset values: `pll_rst`=1, `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0, `busy`=1, `done`=0, `err`=0. The FSM is in RST with its count at 0.
- `cfg_req` in IDLE → `mgmt_write`=1 (MODE) on the next cycle.
- Zero-wait slave: NWORDS+2 writes take 2·(NWORDS+2)−1 cycles from the first `mgmt_write` to the last completion.
- Lock latency after a stable raw lock: 2 (sync) + `LOCK_STABLE` cycles to `lock_q`, then `done` on the next cycle.
- `busy` falls in the same cycle `done` pulses.

## Configuration
- `PLL_SEQ_RELOCK_EN`:
  - Defined: in IDLE, `lock_q` falling (synced lock low for 1 cycle) → RST, full reset/lock sequence, `done` at the end. A pending request is kept.
  - Undefined: lock loss in IDLE is ignored; only requests leave IDLE.

## Structure
- Package `pll_seq_pkg`:
  - State enum.
  - Address constants: `ADDR_MODE`=0, `ADDR_START`=2, `ADDR_N`=3, `ADDR_M`=4, `ADDR_C`=5.
  - Preset word type {addr[5:0], data[31:0]}.
  - Preset table constant [NPRESET][NWORDS].
- Sub-module `pll_lock_qual`: synchronizer plus stability counter, producing `lock_q`.

## Test plan
- Power-up: release `rst_n`; `pll_locked` rises 100 cycles later → `pll_rst` high exactly 16 cycles, `done` 11 cycles after raw lock, `busy`=0.
- Reconfig with preset 2 and zero-wait slave → writes addr 0/1, then table[2] words in order, then addr 2/0. That is 6 strobes each 1 cycle with 1-cycle gaps; `done` after relock.
- Slave holds `mgmt_waitrequest` 5 cycles on the M write → address and data stable for 6 cycles, no extra strobe.
- `cfg_req` with `cfg_sel`=1 during a preset-2 sequence, then `cfg_sel`=3 → after `done`, a preset-3 sequence starts; preset 1 is never issued.
- `pll_locked` held low after START → `err` at 50000 cycles, `pll_rst` pulse, retry. Lock then succeeds → `done`.
- With `PLL_SEQ_RELOCK_EN`, drop `pll_locked` for 1 cycle in IDLE → `busy`=1 and `pll_rst` within 3 cycles. Without the macro, `busy` stays 0.
